// File: rtl/prog_timer_if.sv
// prog_timer_if: control, configuration and status bundle of the programmable timer.
interface prog_timer_if #(
   parameter int WIDTH = 16,
   parameter int PRE_W = 8
);
   logic             t_en;
   logic             t_clr;
   logic             cfg_ld;
   logic [WIDTH-1:0] cfg_limit;
   logic [PRE_W-1:0] cfg_pre;
   logic             cfg_mode;
   logic [WIDTH-1:0] t_out;
   logic             t_valid;
   logic             t_tick;
   logic             t_done;
   modport master (
      output t_en, t_clr, cfg_ld, cfg_limit, cfg_pre, cfg_mode,
      input  t_out, t_valid, t_tick, t_done
   );
   modport slave (
      input  t_en, t_clr, cfg_ld, cfg_limit, cfg_pre, cfg_mode,
      output t_out, t_valid, t_tick, t_done
   );
endinterface

// File: rtl/prog_timer.sv
// prog_timer: prescaled one-shot/periodic up-counter with terminal-count tick and done flag.
module prog_timer #(
   parameter int WIDTH = 16,
   parameter int PRE_W = 8
) (
   input logic        clk,
   input logic        rst,
   prog_timer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
   state_t           state_q;
   logic [WIDTH-1:0] lim_q, out_q, out_d;
   logic [PRE_W-1:0] pre_q, pc_q, pc_d;
   logic             mode_q, tick_q, done_q;
   logic             go, step, hit;
   // go marks every cycle that advances the prescaler, including the IDLE->RUN and PAUSE->RUN edges
   always_comb begin
      go    = bus.t_en && !bus.t_clr &&
              ((state_q == RUN) || (state_q == PAUSE) ||
               ((state_q == IDLE) && !bus.cfg_ld && (lim_q != '0)));
      step  = pc_q == pre_q;
      pc_d  = step ? '0 : pc_q + PRE_W'(1);
      hit   = out_q == lim_q - WIDTH'(1);
      out_d = (out_q == lim_q) ? '0 : out_q + WIDTH'(1);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         out_q   <= '0;
         pc_q    <= '0;
         tick_q  <= 1'b0;
         done_q  <= 1'b0;
         lim_q   <= '1;
         pre_q   <= '0;
         mode_q  <= 1'b1;
      end else begin
         tick_q <= 1'b0;
         if (bus.t_clr) begin
            state_q <= IDLE;
            out_q   <= '0;
            pc_q    <= '0;
            done_q  <= 1'b0;
         end else begin
            if (bus.cfg_ld && ((state_q == IDLE) || (state_q == DONE))) begin
               lim_q  <= bus.cfg_limit;
               pre_q  <= bus.cfg_pre;
               mode_q <= bus.cfg_mode;
            end
            case (state_q)
               IDLE:       state_q <= go ? RUN : IDLE;
               RUN, PAUSE: state_q <= bus.t_en ? RUN : PAUSE;
               DONE: begin
                  if (bus.cfg_ld) begin
                     state_q <= IDLE;
                     out_q   <= '0;
                     pc_q    <= '0;
                     done_q  <= 1'b0;
                  end
               end
            endcase
            if (go) begin
               pc_q <= pc_d;
               if (step) begin
                  out_q  <= out_d;
                  tick_q <= hit;
                  if (hit && !mode_q) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
         end
      end
   end
   assign bus.t_out   = out_q;
   assign bus.t_tick  = tick_q;
   assign bus.t_done  = done_q;
   assign bus.t_valid = (state_q == RUN) || (state_q == DONE);
endmodule

// File: tb/tb_prog_timer.sv
// tb_prog_timer: directed stimulus with a queued scoreboard checked by an independent monitor.
module tb_prog_timer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic samp = 1'b0;
   int   errors = 0;
   int   checks = 0;
   typedef struct {
      string nm;
      int    o;
      bit    v;
      bit    tk;
      bit    dn;
   } exp_t;
   exp_t sb[$];
   prog_timer_if #(.WIDTH(16), .PRE_W(8)) bus ();
   prog_timer #(.WIDTH(16), .PRE_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, pending=%0d", sb.size());
      $fatal(1, "timeout");
   end
   initial begin
      exp_t e;
      forever begin
         @(posedge clk or posedge samp);
         #1;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if ({bus.t_out, bus.t_valid, bus.t_tick, bus.t_done} !== {16'(e.o), e.v, e.tk, e.dn}) begin
               errors++;
               $display("FAIL %s: got out=%0d valid=%b tick=%b done=%b, expected out=%0d valid=%b tick=%b done=%b",
                        e.nm, bus.t_out, bus.t_valid, bus.t_tick, bus.t_done, e.o, e.v, e.tk, e.dn);
            end
         end
      end
   end
   task automatic cyc(input string nm, input int o, input bit v, input bit tk, input bit dn);
      exp_t e;
      e = '{nm, o, v, tk, dn};
      sb.push_back(e);
      @(negedge clk);
   endtask
   task automatic acheck(input string nm, input int o, input bit v, input bit tk, input bit dn);
      exp_t e;
      e = '{nm, o, v, tk, dn};
      sb.push_back(e);
      samp = 1'b1;
      #2 samp = 1'b0;
   endtask
   task automatic skip(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic load(input bit ld, input int lim, input int pre, input bit mode);
      bus.cfg_ld    = ld;
      bus.cfg_limit = 16'(lim);
      bus.cfg_pre   = 8'(pre);
      bus.cfg_mode  = mode;
   endtask
   initial begin
      int os[6] = '{0, 1, 1, 2, 2, 3};
      bus.t_en = 1'b0;
      bus.t_clr = 1'b0;
      load(0, 0, 0, 0);
      @(negedge clk);
      acheck("reset", 0, 0, 0, 0);
      rst = 1'b0;
      bus.t_en = 1'b1;
      cyc("free1", 1, 1, 0, 0);
      cyc("free2", 2, 1, 0, 0);
      cyc("free3", 3, 1, 0, 0);
      skip(65530);
      cyc("pre_wrap", 65534, 1, 0, 0);
      cyc("top_tick", 65535, 1, 1, 0);
      cyc("wrap_zero", 0, 1, 0, 0);
      cyc("after_wrap", 1, 1, 0, 0);
      load(1, 3, 1, 0);
      cyc("ld_in_run", 2, 1, 0, 0);
      load(0, 3, 1, 0);
      cyc("cfg_kept_a", 3, 1, 0, 0);
      cyc("cfg_kept_b", 4, 1, 0, 0);
      bus.t_clr = 1'b1;
      cyc("clr_with_en", 0, 0, 0, 0);
      bus.t_clr = 1'b0;
      bus.t_en = 1'b0;
      load(1, 3, 1, 0);
      cyc("ld_oneshot", 0, 0, 0, 0);
      load(0, 0, 0, 0);
      bus.t_en = 1'b1;
      for (int i = 0; i < 6; i++) cyc("oneshot", os[i], 1, i == 5, i == 5);
      cyc("done_hold_a", 3, 1, 0, 1);
      cyc("done_hold_b", 3, 1, 0, 1);
      bus.t_en = 1'b0;
      cyc("done_en_low", 3, 1, 0, 1);
      bus.t_en = 1'b1;
      load(1, 2, 0, 1);
      cyc("ld_in_done", 0, 0, 0, 0);
      load(0, 0, 0, 0);
      for (int i = 1; i <= 9; i++) cyc("periodic", i % 3, 1, (i % 3) == 2, 0);
      bus.t_clr = 1'b1;
      cyc("clr_periodic", 0, 0, 0, 0);
      bus.t_clr = 1'b0;
      load(1, 0, 0, 1);
      cyc("ld_lim0", 0, 0, 0, 0);
      load(0, 0, 0, 0);
      cyc("lim0_idle_a", 0, 0, 0, 0);
      cyc("lim0_idle_b", 0, 0, 0, 0);
      load(1, 5, 2, 1);
      cyc("ld_with_en", 0, 0, 0, 0);
      load(0, 0, 0, 0);
      for (int e = 1; e <= 4; e++) cyc("pre_run", (e / 3) % 6, 1, (e % 3 == 0) && ((e / 3) % 6 == 5), 0);
      bus.t_en = 1'b0;
      repeat (4) cyc("paused", 1, 0, 0, 0);
      bus.t_en = 1'b1;
      for (int e = 5; e <= 19; e++) cyc("resumed", (e / 3) % 6, 1, (e % 3 == 0) && ((e / 3) % 6 == 5), 0);
      bus.t_clr = 1'b1;
      cyc("clr_resumed", 0, 0, 0, 0);
      bus.t_clr = 1'b0;
      bus.t_en = 1'b0;
      load(1, 20, 1, 0);
      cyc("ld_pre1", 0, 0, 0, 0);
      load(0, 0, 0, 0);
      bus.t_en = 1'b1;
      for (int e = 1; e <= 14; e++) cyc("to_seven", e / 2, 1, 0, 0);
      rst = 1'b1;
      acheck("async_rst", 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      cyc("def_a", 1, 1, 0, 0);
      cyc("def_b", 2, 1, 0, 0);
      cyc("def_c", 3, 1, 0, 0);
      skip(16);
      cyc("def_20", 20, 1, 0, 0);
      cyc("def_21", 21, 1, 0, 0);
      skip(2);
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expected entries left, required 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
